// File: rtl/ex_stage_if.sv
// ex_stage_if: ID/EX-side inputs, EX-stage redirect outputs and EX/MEM register outputs.
interface ex_stage_if #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned RADDR_W = 5
);
  logic               stall_m;
  logic               flush_m;
  logic               valid_e;
  logic [2:0]         alu_control_e;
  logic               alu_src_e;
  logic               branch_e;
  logic               jump_e;
  logic               reg_write_e;
  logic               mem_write_e;
  logic [1:0]         result_src_e;
  logic [XLEN-1:0]    rd1_e;
  logic [XLEN-1:0]    rd2_e;
  logic [XLEN-1:0]    imm_ext_e;
  logic [XLEN-1:0]    pc_e;
  logic [XLEN-1:0]    pc_plus4_e;
  logic [RADDR_W-1:0] rd_e;
  logic [1:0]         forward_a_e;
  logic [1:0]         forward_b_e;
  logic [XLEN-1:0]    result_w;

  logic               pc_src_e;
  logic [XLEN-1:0]    pc_target_e;
  logic               valid_m;
  logic               reg_write_m;
  logic               mem_write_m;
  logic [1:0]         result_src_m;
  logic [XLEN-1:0]    alu_result_m;
  logic [XLEN-1:0]    write_data_m;
  logic [XLEN-1:0]    pc_plus4_m;
  logic [RADDR_W-1:0] rd_m;

  // Pipeline/hazard side driving the execute stage.
  modport master (
    output stall_m, flush_m, valid_e, alu_control_e, alu_src_e, branch_e, jump_e,
           reg_write_e, mem_write_e, result_src_e, rd1_e, rd2_e, imm_ext_e, pc_e,
           pc_plus4_e, rd_e, forward_a_e, forward_b_e, result_w,
    input  pc_src_e, pc_target_e, valid_m, reg_write_m, mem_write_m, result_src_m,
           alu_result_m, write_data_m, pc_plus4_m, rd_m
  );

  // Execute stage itself.
  modport slave (
    input  stall_m, flush_m, valid_e, alu_control_e, alu_src_e, branch_e, jump_e,
           reg_write_e, mem_write_e, result_src_e, rd1_e, rd2_e, imm_ext_e, pc_e,
           pc_plus4_e, rd_e, forward_a_e, forward_b_e, result_w,
    output pc_src_e, pc_target_e, valid_m, reg_write_m, mem_write_m, result_src_m,
           alu_result_m, write_data_m, pc_plus4_m, rd_m
  );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: RV32I execute stage -- operand forwarding, ALU, branch/jump decision,
// and the EX/MEM pipeline register.
// Optional feature macro: EX_FWD_EN (operand forwarding muxes; without it the
// hazard unit is expected to stall on every RAW hazard).
module ex_stage #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned RADDR_W = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  ex_stage_if.slave  bus
);

  logic [XLEN-1:0]    src_a;
  logic [XLEN-1:0]    src_b_reg;
  logic [XLEN-1:0]    src_b;
  logic [XLEN-1:0]    alu_result;
  logic               zero;

  logic               valid_q;
  logic               reg_write_q;
  logic               mem_write_q;
  logic [1:0]         result_src_q;
  logic [XLEN-1:0]    alu_result_q;
  logic [XLEN-1:0]    write_data_q;
  logic [XLEN-1:0]    pc_plus4_q;
  logic [RADDR_W-1:0] rd_q;

`ifdef EX_FWD_EN
  // Operand forwarding; path 10 takes the registered result of the instruction now in MEM.
  always_comb begin
    src_a     = bus.rd1_e;
    src_b_reg = bus.rd2_e;
    case (bus.forward_a_e)
      2'b01:   src_a = bus.result_w;
      2'b10:   src_a = alu_result_q;
      default: src_a = bus.rd1_e;
    endcase
    case (bus.forward_b_e)
      2'b01:   src_b_reg = bus.result_w;
      2'b10:   src_b_reg = alu_result_q;
      default: src_b_reg = bus.rd2_e;
    endcase
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{bus.forward_a_e, bus.forward_b_e, bus.result_w};

  // No forwarding: operands come straight from the register file.
  always_comb begin
    src_a     = bus.rd1_e;
    src_b_reg = bus.rd2_e;
  end
`endif

  assign src_b = bus.alu_src_e ? bus.imm_ext_e : src_b_reg;

  // ALU; undefined control codes produce 0 rather than X.
  always_comb begin
    alu_result = '0;
    case (bus.alu_control_e)
      3'b000:  alu_result = src_a + src_b;
      3'b001:  alu_result = src_a - src_b;
      3'b010:  alu_result = src_a & src_b;
      3'b011:  alu_result = src_a | src_b;
      3'b110:  alu_result = XLEN'($signed(src_a) < $signed(src_b));
      default: alu_result = '0;
    endcase
  end

  assign zero            = (alu_result == '0);
  assign bus.pc_src_e    = bus.valid_e & ((bus.branch_e & zero) | bus.jump_e);
  assign bus.pc_target_e = bus.pc_e + bus.imm_ext_e;

  // EX/MEM register: flush kills controls (data holds), stall holds everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      result_src_q <= '0;
      alu_result_q <= '0;
      write_data_q <= '0;
      pc_plus4_q   <= '0;
      rd_q         <= '0;
    end else if (bus.flush_m) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
    end else if (!bus.stall_m) begin
      valid_q      <= bus.valid_e;
      reg_write_q  <= bus.reg_write_e & bus.valid_e;
      mem_write_q  <= bus.mem_write_e & bus.valid_e;
      result_src_q <= bus.result_src_e;
      alu_result_q <= alu_result;
      write_data_q <= src_b_reg;
      pc_plus4_q   <= bus.pc_plus4_e;
      rd_q         <= bus.rd_e;
    end
  end

  assign bus.valid_m      = valid_q;
  assign bus.reg_write_m  = reg_write_q;
  assign bus.mem_write_m  = mem_write_q;
  assign bus.result_src_m = result_src_q;
  assign bus.alu_result_m = alu_result_q;
  assign bus.write_data_m = write_data_q;
  assign bus.pc_plus4_m   = pc_plus4_q;
  assign bus.rd_m         = rd_q;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed and randomized checks of ex_stage against a behavioural model.
module tb_ex_stage;
  localparam int unsigned XLEN    = 32;
  localparam int unsigned RADDR_W = 5;
`ifdef EX_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  ex_stage_if #(.XLEN(XLEN), .RADDR_W(RADDR_W)) bus ();
  ex_stage #(.XLEN(XLEN), .RADDR_W(RADDR_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected EX/MEM contents
  logic        m_valid, m_rw, m_mw;
  logic [1:0]  m_rs;
  logic [31:0] m_alu, m_wd, m_pc4;
  logic [4:0]  m_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] rd);
    if (FWD_EN && sel == 2'b01) return bus.result_w;
    if (FWD_EN && sel == 2'b10) return m_alu;
    return rd;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [2:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
    int sa, sb;
    sa = int'(a);
    sb = int'(b);
    case (c)
      3'd0:    return 32'(sa + sb);
      3'd1:    return 32'(sa - sb);
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd6:    return (sa < sb) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] cur_alu();
    logic [31:0] b;
    b = bus.alu_src_e ? bus.imm_ext_e : fwd(bus.forward_b_e, bus.rd2_e);
    return ref_alu(bus.alu_control_e, fwd(bus.forward_a_e, bus.rd1_e), b);
  endfunction

  task automatic model_reset();
    m_valid = 0; m_rw = 0; m_mw = 0; m_rs = 0;
    m_alu = 0; m_wd = 0; m_pc4 = 0; m_rd = 0;
  endtask

  // Advance the model across one rising edge using the currently driven inputs.
  task automatic model_edge();
    logic [31:0] alu, wd;
    alu = cur_alu();
    wd  = fwd(bus.forward_b_e, bus.rd2_e);
    if (!rst_n) model_reset();
    else if (bus.flush_m) begin
      m_valid = 0; m_rw = 0; m_mw = 0;
    end else if (!bus.stall_m) begin
      m_valid = bus.valid_e;
      m_rw    = bus.reg_write_e && bus.valid_e;
      m_mw    = bus.mem_write_e && bus.valid_e;
      m_rs    = bus.result_src_e;
      m_alu   = alu;
      m_wd    = wd;
      m_pc4   = bus.pc_plus4_e;
      m_rd    = bus.rd_e;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_comb(input string tag);
    logic exp_src;
    exp_src = bus.valid_e && ((bus.branch_e && cur_alu() == 32'd0) || bus.jump_e);
    chk({tag, ".pc_src"}, 32'(bus.pc_src_e), 32'(exp_src));
    chk({tag, ".pc_target"}, bus.pc_target_e, bus.pc_e + bus.imm_ext_e);
  endtask

  task automatic check_m(input string tag);
    chk({tag, ".valid_m"}, 32'(bus.valid_m), 32'(m_valid));
    chk({tag, ".reg_write_m"}, 32'(bus.reg_write_m), 32'(m_rw));
    chk({tag, ".mem_write_m"}, 32'(bus.mem_write_m), 32'(m_mw));
    chk({tag, ".result_src_m"}, 32'(bus.result_src_m), 32'(m_rs));
    chk({tag, ".alu_result_m"}, bus.alu_result_m, m_alu);
    chk({tag, ".write_data_m"}, bus.write_data_m, m_wd);
    chk({tag, ".pc_plus4_m"}, bus.pc_plus4_m, m_pc4);
    chk({tag, ".rd_m"}, 32'(bus.rd_m), 32'(m_rd));
  endtask

  task automatic drive_nop();
    bus.stall_m = 0; bus.flush_m = 0; bus.valid_e = 0; bus.alu_control_e = 0;
    bus.alu_src_e = 0; bus.branch_e = 0; bus.jump_e = 0; bus.reg_write_e = 0;
    bus.mem_write_e = 0; bus.result_src_e = 0; bus.rd1_e = 0; bus.rd2_e = 0;
    bus.imm_ext_e = 0; bus.pc_e = 0; bus.pc_plus4_e = 0; bus.rd_e = 0;
    bus.forward_a_e = 0; bus.forward_b_e = 0; bus.result_w = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    drive_nop();
    model_reset();
    #1;
    check_m("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // add with immediate
    bus.valid_e = 1; bus.reg_write_e = 1; bus.alu_src_e = 1; bus.rd1_e = 5;
    bus.imm_ext_e = 7; bus.rd_e = 5'd3; bus.pc_plus4_e = 32'h8; bus.result_src_e = 2'b01;
    step();
    chk("add.alu", bus.alu_result_m, 32'd12);
    chk("add.rw", 32'(bus.reg_write_m), 32'd1);
    check_m("add");

    // beq taken, then the same as a bubble with write enables set
    drive_nop();
    bus.valid_e = 1; bus.branch_e = 1; bus.alu_control_e = 3'b001; bus.rd1_e = 9;
    bus.rd2_e = 9; bus.pc_e = 32'h100; bus.imm_ext_e = 32'h20;
    #1;
    chk("beq.pc_src", 32'(bus.pc_src_e), 32'd1);
    chk("beq.target", bus.pc_target_e, 32'h120);
    step();
    check_m("beq");
    bus.valid_e = 0; bus.reg_write_e = 1; bus.mem_write_e = 1;
    #1;
    chk("bubble.pc_src", 32'(bus.pc_src_e), 32'd0);
    step();
    chk("bubble.rw", 32'(bus.reg_write_m), 32'd0);
    chk("bubble.mw", 32'(bus.mem_write_m), 32'd0);
    check_m("bubble");

    // signed set-less-than both ways
    drive_nop();
    bus.valid_e = 1; bus.alu_control_e = 3'b110; bus.rd1_e = 32'hFFFF_FFFF; bus.rd2_e = 1;
    step();
    chk("slt1.alu", bus.alu_result_m, 32'd1);
    bus.rd1_e = 1; bus.rd2_e = 32'hFFFF_FFFF;
    step();
    chk("slt2.alu", bus.alu_result_m, 32'd0);
    check_m("slt2");

    // forwarding from MEM (path 10) and WB (path 01)
    drive_nop();
    bus.valid_e = 1; bus.alu_src_e = 1; bus.rd1_e = 32'h40;
    step();
    bus.alu_src_e = 0; bus.rd1_e = 32'h111; bus.rd2_e = 32'h222;
    bus.forward_a_e = 2'b10; bus.forward_b_e = 2'b01; bus.result_w = 3;
    step();
    chk("fwd.alu", bus.alu_result_m, FWD_EN ? 32'h43 : 32'h333);
    chk("fwd.wd", bus.write_data_m, FWD_EN ? 32'h3 : 32'h222);
    check_m("fwd");

    // stall holds for two cycles, then stall+flush kills controls
    drive_nop();
    bus.valid_e = 1; bus.reg_write_e = 1; bus.mem_write_e = 1; bus.rd1_e = 32'h1234;
    bus.rd_e = 5'd7; bus.pc_plus4_e = 32'h44;
    step();
    bus.stall_m = 1; bus.rd1_e = 32'h9999; bus.rd_e = 5'd9; bus.pc_plus4_e = 32'h88;
    step();
    check_m("stall1");
    step();
    check_m("stall2");
    chk("stall.alu", bus.alu_result_m, 32'h1234);
    bus.flush_m = 1;
    step();
    chk("flush.valid", 32'(bus.valid_m), 32'd0);
    chk("flush.mw", 32'(bus.mem_write_m), 32'd0);
    check_m("flush");

    // async reset during a stall
    bus.flush_m = 0;
    step();
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_m("rst_mid");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_m("rst_hold");

    // undefined control code -> 0, so a branch is taken
    drive_nop();
    bus.valid_e = 1; bus.branch_e = 1; bus.alu_control_e = 3'b111;
    bus.rd1_e = 5; bus.rd2_e = 6;
    #1;
    chk("ctl7.pc_src", 32'(bus.pc_src_e), 32'd1);
    step();
    chk("ctl7.alu", bus.alu_result_m, 32'd0);

    // randomized traffic
    for (int i = 0; i < 200; i++) begin
      bus.stall_m       = ($urandom_range(0, 5) == 0);
      bus.flush_m       = ($urandom_range(0, 7) == 0);
      bus.valid_e       = ($urandom_range(0, 3) != 0);
      bus.alu_control_e = 3'($urandom_range(0, 7));
      bus.alu_src_e     = 1'($urandom_range(0, 1));
      bus.branch_e      = 1'($urandom_range(0, 1));
      bus.jump_e        = ($urandom_range(0, 4) == 0);
      bus.reg_write_e   = 1'($urandom_range(0, 1));
      bus.mem_write_e   = 1'($urandom_range(0, 1));
      bus.result_src_e  = 2'($urandom_range(0, 3));
      bus.rd1_e         = $urandom;
      bus.rd2_e         = ($urandom_range(0, 3) == 0) ? bus.rd1_e : $urandom;
      bus.imm_ext_e     = $urandom;
      bus.pc_e          = $urandom;
      bus.pc_plus4_e    = bus.pc_e + 32'd4;
      bus.rd_e          = 5'($urandom_range(0, 31));
      bus.forward_a_e   = 2'($urandom_range(0, 3));
      bus.forward_b_e   = 2'($urandom_range(0, 3));
      bus.result_w      = $urandom;
      #1;
      check_comb("rnd");
      step();
      check_m("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
